// File: rtl/mem_dma_engine.sv
// mem_dma_engine: word-at-a-time memory-to-memory copy engine; optional constant fill mode under `DMA_FILL_EN.
// Latency: 3 cycles/word for a copy (rdy=1, 1-cycle read latency), 1 cycle/word for a fill; done pulses the cycle after the last write.
// Backpressure: each request is held stable until mem_req_rdy; RD_WAIT waits indefinitely for mem_resp_val.
module mem_dma_engine #(
    parameter int CPU_WIDTH      = 32,
    parameter int WORD_ADDR_BITS = 30,
    parameter int LEN_BITS       = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [WORD_ADDR_BITS-1:0] src_addr,
    input  logic [WORD_ADDR_BITS-1:0] dst_addr,
    input  logic [LEN_BITS-1:0]       len,
`ifdef DMA_FILL_EN
    input  logic                      fill_mode,
    input  logic [CPU_WIDTH-1:0]      fill_value,
`endif
    output logic                      busy,
    output logic                      done,
    output logic [LEN_BITS-1:0]       words_done,
    output logic                      mem_req_val,
    input  logic                      mem_req_rdy,
    output logic [WORD_ADDR_BITS-1:0] mem_req_addr,
    output logic [CPU_WIDTH-1:0]      mem_req_data,
    output logic [3:0]                mem_req_write,
    input  logic                      mem_resp_val,
    input  logic [CPU_WIDTH-1:0]      mem_resp_data
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] RD_REQ  = 3'd1;
    localparam logic [2:0] RD_WAIT = 3'd2;
    localparam logic [2:0] WR_REQ  = 3'd3;
    localparam logic [2:0] DONE    = 3'd4;

    localparam logic [LEN_BITS-1:0]       LEN_ONE  = {{(LEN_BITS-1){1'b0}}, 1'b1};
    localparam logic [WORD_ADDR_BITS-1:0] ADDR_ONE = {{(WORD_ADDR_BITS-1){1'b0}}, 1'b1};

    logic [2:0]                state;
    logic [2:0]                state_nxt;
    logic [WORD_ADDR_BITS-1:0] src_q;
    logic [WORD_ADDR_BITS-1:0] dst_q;
    logic [LEN_BITS-1:0]       len_q;
    logic [CPU_WIDTH-1:0]      data_q;
    logic [LEN_BITS-1:0]       wd_next;
    logic                      fill_start;
    logic                      fill_act;

`ifdef DMA_FILL_EN
    logic fill_q;

    assign fill_start = fill_mode;
    assign fill_act   = fill_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            fill_q <= 1'b0;
        end else if (state == IDLE && start) begin
            fill_q <= fill_mode;
        end
    end
`else
    assign fill_start = 1'b0;
    assign fill_act   = 1'b0;
`endif

    assign wd_next = words_done + LEN_ONE;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    if (len == '0) begin
                        state_nxt = DONE;
                    end else if (fill_start) begin
                        state_nxt = WR_REQ;
                    end else begin
                        state_nxt = RD_REQ;
                    end
                end
            end
            RD_REQ: begin
                if (mem_req_rdy) begin
                    state_nxt = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (mem_resp_val) begin
                    state_nxt = WR_REQ;
                end
            end
            WR_REQ: begin
                // Fill transfers stay in WR_REQ so each word costs one cycle.
                if (mem_req_rdy) begin
                    if (wd_next == len_q) begin
                        state_nxt = DONE;
                    end else if (fill_act) begin
                        state_nxt = WR_REQ;
                    end else begin
                        state_nxt = RD_REQ;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            src_q      <= '0;
            dst_q      <= '0;
            len_q      <= '0;
            data_q     <= '0;
            words_done <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        src_q      <= src_addr;
                        dst_q      <= dst_addr;
                        len_q      <= len;
                        words_done <= '0;
`ifdef DMA_FILL_EN
                        if (fill_mode) begin
                            data_q <= fill_value;
                        end
`endif
                    end
                end
                RD_WAIT: begin
                    if (mem_resp_val) begin
                        data_q <= mem_resp_data;
                    end
                end
                WR_REQ: begin
                    // Addresses wrap naturally at the top of the word address space.
                    if (mem_req_rdy) begin
                        words_done <= wd_next;
                        src_q      <= src_q + ADDR_ONE;
                        dst_q      <= dst_q + ADDR_ONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy          = (state != IDLE);
    assign done          = (state == DONE);
    assign mem_req_val   = (state == RD_REQ) || (state == WR_REQ);
    assign mem_req_write = (state == WR_REQ) ? 4'b1111 : 4'b0000;
    assign mem_req_addr  = (state == WR_REQ) ? dst_q : src_q;
    assign mem_req_data  = data_q;

endmodule

// File: doc/mem_dma_engine.md
MEM_DMA_ENGINE -- requirements
Module: mem_dma_engine

Interface
REQ-001 SHALL have parameter CPU_WIDTH, default 32, the data word width in bits.
REQ-002 SHALL have parameter WORD_ADDR_BITS, default 30, the word address width.
REQ-003 SHALL have parameter LEN_BITS, default 16, the transfer length counter width.
REQ-004 SHALL have port clk, input, 1 bit: the clock; all logic is on the rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port start, input, 1 bit: transfer request, sampled only in IDLE.
REQ-007 SHALL have ports src_addr and dst_addr, input, WORD_ADDR_BITS each: first source and destination word addresses.
REQ-008 SHALL have port len, input, LEN_BITS: number of words to transfer.
REQ-009 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-010 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-011 SHALL have port words_done, output, LEN_BITS: count of words written in the current or last transfer.
REQ-012 SHALL have the memory master ports mem_req_val (out, 1), mem_req_rdy (in, 1), mem_req_addr (out, WORD_ADDR_BITS), mem_req_data (out, CPU_WIDTH), mem_req_write (out, 4; byte enables, 0 = read), mem_resp_val (in, 1) and mem_resp_data (in, CPU_WIDTH).

Function
REQ-013 SHALL implement the states IDLE, RD_REQ, RD_WAIT, WR_REQ and DONE.
REQ-014 SHALL, in IDLE with start=1 and len!=0, latch src_addr, dst_addr and len, clear words_done, and enter RD_REQ on the next edge.
REQ-015 SHALL, in IDLE with start=1 and len=0, go to DONE without issuing any request.
REQ-016 SHALL, in RD_REQ, drive mem_req_val=1, mem_req_write=4'b0000 and mem_req_addr=current source address.
REQ-017 SHALL enter RD_WAIT on the edge where mem_req_val and mem_req_rdy are both 1.
REQ-018 SHALL, in RD_WAIT, capture mem_resp_data into a data register and enter WR_REQ on the first cycle with mem_resp_val=1; it waits indefinitely otherwise.
REQ-019 SHALL, in WR_REQ, drive mem_req_val=1, mem_req_write=4'b1111, mem_req_addr=current destination address and mem_req_data=the captured word.
REQ-020 SHALL, on write acceptance, increment words_done and both addresses modulo 2^WORD_ADDR_BITS (wrap-around permitted), then enter DONE if words_done+1==latched len, else RD_REQ.
REQ-021 SHALL hold mem_req_val, mem_req_addr, mem_req_data and mem_req_write stable while mem_req_val=1 and mem_req_rdy=0.
REQ-022 SHALL keep mem_req_val=0 in IDLE, RD_WAIT and DONE.
REQ-023 SHALL, in DONE, assert done=1 for exactly one cycle and return to IDLE.
REQ-024 SHALL ignore start while busy=1, and SHALL ignore mem_resp_val outside RD_WAIT.
REQ-025 SHALL, with mem_req_rdy=1 and a memory read latency of 1 cycle, take 3 cycles per word, with done asserted 3*len+1 cycles after the start edge.

Reset
REQ-026 SHALL, on reset=1 at any time including mid-transfer, enter IDLE and drive busy=0, done=0, mem_req_val=0, mem_req_write=0 and words_done=0 on the following cycle, abandoning any outstanding request.

Configuration
REQ-027 SHALL, with DMA_FILL_EN defined, add the inputs fill_mode (1 bit) and fill_value (CPU_WIDTH), both latched at start; when fill_mode=1 the engine SHALL skip RD_REQ/RD_WAIT and write the latched fill_value to len words, going IDLE->WR_REQ, at 1 cycle per word with rdy=1.
REQ-028 SHALL, without DMA_FILL_EN, omit those ports and always perform a copy.

Verification
REQ-029 The bench SHALL load mem[0x100..0x103]=A,B,C,D, then start with src=0x100, dst=0x200, len=4 and rdy=1 -> mem[0x200..0x203]=A,B,C,D, done 13 cycles after start, words_done=4.
REQ-030 The bench SHALL start with len=0 -> no mem_req_val, done pulses on the second cycle, words_done=0.
REQ-031 The bench SHALL hold rdy=0 for 5 cycles during each request with len=2 -> request fields stay stable, data is correct and there are no duplicate writes.
REQ-032 The bench SHALL start with src=0x3FFFFFFF and len=2 -> the second read goes to address 0x0.
REQ-033 The bench SHALL assert reset during RD_WAIT -> idle outputs on the next cycle, and a later start with len=1 completes normally.
REQ-034 The bench SHALL, with DMA_FILL_EN defined, start with fill_mode=1, fill_value=0xDEADBEEF, dst=0x10 and len=3 -> mem[0x10..0x12]=0xDEADBEEF, no reads issued, done 4 cycles after start.
